// File: rtl/pwm_capture.sv
// PWM capture: synchronises an asynchronous PWM line and measures period and
// high time in clock cycles, flagging a line stuck high or low on timeout.
module pwm_capture #(
   parameter int unsigned CNT_W   = 16,
   parameter int unsigned TIMEOUT = 4096
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             pwm_in,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             valid,
   output logic             stuck_high,
   output logic             stuck_low,
   output logic             active
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic {
      IDLE  = 1'b0,
      ARMED = 1'b1
   } state_t;

   state_t           state, state_nxt;
   logic             s1, s2, d;
   logic             rise, fall;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [CNT_W-1:0] high_lat, high_lat_nxt;
   logic [CNT_W-1:0] period_nxt, high_time_nxt;
   logic             valid_nxt, stuck_high_nxt, stuck_low_nxt, active_nxt;

   // Synchroniser and edge-detect delay; preset high so a line high at reset
   // release is not mistaken for a rising edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= 1'b1;
         s2 <= 1'b1;
         d  <= 1'b1;
      end else begin
         s1 <= pwm_in;
         s2 <= s1;
         d  <= s2;
      end
   end

   assign rise = s2 & ~d;
   assign fall = ~s2 & d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         high_lat   <= '0;
         period     <= '0;
         high_time  <= '0;
         valid      <= 1'b0;
         stuck_high <= 1'b0;
         stuck_low  <= 1'b0;
         active     <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         high_lat   <= high_lat_nxt;
         period     <= period_nxt;
         high_time  <= high_time_nxt;
         valid      <= valid_nxt;
         stuck_high <= stuck_high_nxt;
         stuck_low  <= stuck_low_nxt;
         active     <= active_nxt;
      end
   end

   // Rise beats timeout in the same cycle; a coincident fall still latches high_lat.
   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      high_lat_nxt   = high_lat;
      period_nxt     = period;
      high_time_nxt  = high_time;
      valid_nxt      = 1'b0;
      stuck_high_nxt = stuck_high;
      stuck_low_nxt  = stuck_low;

      if (!en) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
      end else begin
         if (rise) begin
            cnt_nxt = CNT_ONE;
         end else if (cnt != CNT_MAX) begin
            cnt_nxt = cnt + CNT_ONE;
         end

         if (fall) begin
            high_lat_nxt = cnt;
         end

         case (state)
            IDLE: begin
               if (rise) begin
                  state_nxt      = ARMED;
                  stuck_high_nxt = 1'b0;
                  stuck_low_nxt  = 1'b0;
               end
            end
            ARMED: begin
               if (rise) begin
                  period_nxt    = cnt;
                  high_time_nxt = high_lat;
                  valid_nxt     = 1'b1;
               end else if (cnt == CNT_MAX) begin
                  state_nxt      = IDLE;
                  stuck_high_nxt = s2;
                  stuck_low_nxt  = ~s2;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end

      active_nxt = (state_nxt == ARMED);
   end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: two instances (TIMEOUT 4096 and 100) share one
// stimulus; expectations come from a waveform-segment model of the line.
module tb_pwm_capture;

   localparam int unsigned CNT_W = 16;
   localparam int          TO_A  = 4096;
   localparam int          TO_B  = 100;

   logic             clk = 1'b0;
   logic             rst, en, pwm_in;
   logic [CNT_W-1:0] period_a, high_a, period_b, high_b;
   logic             valid_a, sh_a, sl_a, act_a;
   logic             valid_b, sh_b, sl_b, act_b;

   always #5 clk = ~clk;

   pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TO_A)) dut_a (
      .clk(clk), .rst(rst), .en(en), .pwm_in(pwm_in),
      .period(period_a), .high_time(high_a), .valid(valid_a),
      .stuck_high(sh_a), .stuck_low(sl_a), .active(act_a)
   );

   pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TO_B)) dut_b (
      .clk(clk), .rst(rst), .en(en), .pwm_in(pwm_in),
      .period(period_b), .high_time(high_b), .valid(valid_b),
      .stuck_high(sh_b), .stuck_low(sl_b), .active(act_b)
   );

   typedef struct {
      int p;
      int h;
   } meas_t;

   meas_t got_a[$], got_b[$], exp_a[$], exp_b[$];
   int    n_tests = 0;
   int    n_fail  = 0;

   // Model state: cycles since the last driven rise, high time of the current
   // period, and per-instance armed/stuck/published values.
   int to_v[2] = '{TO_A, TO_B};
   bit armed[2];
   bit st_h[2];
   bit st_l[2];
   int ep[2];
   int eh[2];
   int since;
   int high;
   bit last;

   always @(negedge clk) begin
      if (valid_a) got_a.push_back('{int'(period_a), int'(high_a)});
      if (valid_b) got_b.push_back('{int'(period_b), int'(high_b)});
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic void timeout(input int k, input bit lvl);
      armed[k] = 1'b0;
      st_h[k]  = lvl;
      st_l[k]  = !lvl;
   endfunction

   function automatic void publish(input int k);
      if (k == 0) exp_a.push_back('{since, high});
      else        exp_b.push_back('{since, high});
      ep[k] = since;
      eh[k] = high;
   endfunction

   // Hold the line at level for n cycles and advance the model accordingly.
   task automatic seg(input bit level, input int n);
      bit r, f;
      r = level && !last;
      f = !level && last;
      for (int k = 0; k < 2; k++)
         if (armed[k] && since == to_v[k] && !r) timeout(k, level);
      if (f) high = since;
      if (r) begin
         for (int k = 0; k < 2; k++) begin
            if (armed[k]) publish(k);
            armed[k] = 1'b1;
            st_h[k]  = 1'b0;
            st_l[k]  = 1'b0;
         end
         since = 0;
      end
      for (int k = 0; k < 2; k++)
         if (armed[k] && since < to_v[k] && since + n > to_v[k]) timeout(k, level);
      since += n;
      last   = level;
      pwm_in = level;
      repeat (n) @(negedge clk);
   endtask

   task automatic en_low(input int n);
      en = 1'b0;
      for (int k = 0; k < 2; k++) armed[k] = 1'b0;
      repeat (n) @(negedge clk);
      since += n;
      en = 1'b1;
   endtask

   task automatic rst_pulse();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      since += 1;
      for (int k = 0; k < 2; k++) begin
         armed[k] = 1'b0;
         st_h[k]  = 1'b0;
         st_l[k]  = 1'b0;
         ep[k]    = 0;
         eh[k]    = 0;
      end
   endtask

   task automatic check_dut(input int k, input string tag);
      meas_t g[$], e[$];
      int    gp, gh, gsh, gsl, gact;
      string nm;
      nm = (k == 0) ? "a" : "b";
      if (k == 0) begin
         g = got_a; e = exp_a;
         gp = int'(period_a); gh = int'(high_a);
         gsh = int'(sh_a); gsl = int'(sl_a); gact = int'(act_a);
      end else begin
         g = got_b; e = exp_b;
         gp = int'(period_b); gh = int'(high_b);
         gsh = int'(sh_b); gsl = int'(sl_b); gact = int'(act_b);
      end
      chk($sformatf("%s.%s.nvalid", tag, nm), g.size(), e.size());
      for (int i = 0; i < g.size() && i < e.size(); i++) begin
         chk($sformatf("%s.%s.v%0d.period", tag, nm, i), g[i].p, e[i].p);
         chk($sformatf("%s.%s.v%0d.high", tag, nm, i), g[i].h, e[i].h);
      end
      chk($sformatf("%s.%s.period", tag, nm), gp, ep[k]);
      chk($sformatf("%s.%s.high_time", tag, nm), gh, eh[k]);
      chk($sformatf("%s.%s.stuck_high", tag, nm), gsh, int'(st_h[k]));
      chk($sformatf("%s.%s.stuck_low", tag, nm), gsl, int'(st_l[k]));
      chk($sformatf("%s.%s.active", tag, nm), gact, int'(armed[k]));
   endtask

   // Let the sync pipeline drain and keep clear of an unresolved timeout
   // before comparing.
   task automatic check_all(input string tag);
      bit near;
      for (int it = 0; it < 3; it++) begin
         near = 1'b0;
         for (int k = 0; k < 2; k++)
            if (armed[k] && since <= to_v[k] && since + 15 >= to_v[k]) near = 1'b1;
         if (near) seg(last, 25);
      end
      seg(last, 4);
      check_dut(0, tag);
      check_dut(1, tag);
      got_a.delete(); got_b.delete();
      exp_a.delete(); exp_b.delete();
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; pwm_in = 1'b1;
      since = 0; high = 0; last = 1'b1;
      for (int k = 0; k < 2; k++) begin
         armed[k] = 1'b0; st_h[k] = 1'b0; st_l[k] = 1'b0; ep[k] = 0; eh[k] = 0;
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_dut(0, "reset");
      check_dut(1, "reset");

      // Line high through reset release: no rise, no flags.
      seg(1'b1, 4200);
      check_all("hold_high_idle");

      // Duty 3 of 256.
      seg(1'b0, 253);
      repeat (4) begin
         seg(1'b1, 3);
         seg(1'b0, 253);
      end
      seg(1'b1, 3);
      check_all("duty3");

      // Line stuck low, then duty 5.
      seg(1'b0, 4200);
      check_all("stuck_low");
      seg(1'b1, 5); seg(1'b0, 251);
      check_all("duty5_arm");
      seg(1'b1, 5); seg(1'b0, 251); seg(1'b1, 5);
      check_all("duty5");

      // Armed, then line held high past timeout.
      seg(1'b1, 4200);
      check_all("stuck_high");

      // Fastest waveform, then 10/40.
      seg(1'b0, 2);
      repeat (10) begin
         seg(1'b1, 1);
         seg(1'b0, 1);
      end
      seg(1'b1, 1);
      check_all("fastest");
      seg(1'b0, 30);
      repeat (3) begin
         seg(1'b1, 10);
         seg(1'b0, 30);
      end
      seg(1'b1, 10);
      check_all("p40_h10");

      // Randomised periods around the short timeout.
      for (int b = 0; b < 3; b++) begin
         repeat (20) begin
            seg(1'b0, int'($urandom_range(1, 80)));
            seg(1'b1, int'($urandom_range(1, 40)));
         end
         check_all($sformatf("random%0d", b));
      end

      // Enable dropped mid-period.
      seg(1'b0, 20);
      check_all("pre_en");
      en_low(5);
      check_all("en_low_hold");
      seg(1'b0, 20);
      seg(1'b1, 7); seg(1'b0, 33);
      check_all("en_first_rise");
      seg(1'b1, 7); seg(1'b0, 33); seg(1'b1, 7);
      check_all("en_second_rise");

      // Reset pulse mid-period.
      seg(1'b0, 20);
      rst_pulse();
      check_all("rst_pulse");
      seg(1'b1, 7); seg(1'b0, 33);
      check_all("rst_first_rise");
      seg(1'b1, 7); seg(1'b0, 33); seg(1'b1, 7);
      check_all("rst_second_rise");

      // Period exactly at and just beyond the short timeout.
      seg(1'b0, 50);
      seg(1'b1, 10); seg(1'b0, 90);
      seg(1'b1, 10); seg(1'b0, 90);
      seg(1'b1, 10);
      check_all("p100_rise_wins");
      seg(1'b0, 97);
      check_all("p101_timeout");
      seg(1'b1, 10);
      check_all("p101_rearm");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Receiving end of the PWM link: samples an asynchronous PWM waveform and measures its period and high time in clock cycles.
- Publishes a measurement after every complete period, flagged with a one-cycle valid strobe.
- Flags a line stuck high or stuck low when no rising edge arrives within a timeout.
- Used to close the loop on PWM outputs (self-test, fan tach/duty readback) in the same clock domain as the generator.

Parameters:
- CNT_W, 16, width of the cycle counter and of the period/high_time outputs.
- TIMEOUT, 4096, cycles without a rising edge before the capture declares the line stuck; must satisfy 2 <= TIMEOUT <= 2**CNT_W-1.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  capture enable; low forces IDLE and holds the outputs.
- pwm_in  input  1  PWM waveform, asynchronous to clk.
- period  output  CNT_W  last measured period, rising edge to rising edge, in cycles.
- high_time  output  CNT_W  high time within that period, in cycles.
- valid  output  1  one-cycle strobe when period/high_time update.
- stuck_high  output  1  timeout expired with the line high.
- stuck_low  output  1  timeout expired with the line low.
- active  output  1  high when state is ARMED.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst). Every register updates only on posedge clk.
- Reset values: period=0, high_time=0, valid=0, stuck_high=0, stuck_low=0, active=0, state=IDLE, cnt=0, high_lat=0.
- Synchroniser and edge detect:
  - Two-flop synchroniser s1→s2, then delay register d.
  - s1, s2 and d all reset to 1, so a line that is high at reset release produces no false rise.
  - rise = s2 & ~d; fall = ~s2 & d.
- Latency: a pwm_in transition sampled at clock edge N appears as rise/fall during cycle N+1. Registered outputs update at edge N+2.
- Counter cnt:
  - On rise, cnt <= 1.
  - Otherwise cnt <= cnt+1, saturating at TIMEOUT.
  - On fall, high_lat <= cnt.
- States:
  - IDLE: no timing reference.
    - rise → ARMED. No valid is issued. stuck_high and stuck_low are cleared.
    - fall is ignored.
  - ARMED: measuring.
    - On rise: period <= cnt, high_time <= high_lat, valid <= 1 for exactly one cycle; stay ARMED.
    - If cnt == TIMEOUT and no rise this cycle: go to IDLE, set stuck_high = s2 and stuck_low = ~s2. period and high_time hold their last values.
- Result for a waveform high for H cycles out of P cycles (steady state): period = P, high_time = H. Minimum measurable waveform is H=1, P=2.
- Counter ordering:
  - rise takes priority over the timeout check in the same cycle.
  - A fall in the same cycle as the timeout still latches high_lat before the state goes to IDLE.
- en low:
  - Next cycle: state=IDLE, valid=0, cnt=0.
  - period, high_time and the stuck flags hold.
  - The synchroniser keeps running.
  - When en is re-asserted, the first valid appears after two rising edges.
- rst asserted mid-measurement: all registers return to reset values on the next edge, and no valid is issued for the partial period.
- valid is never asserted in two consecutive cycles, since rises are at least 2 cycles apart after synchronisation.

Test Plan:
1. Drive the team PWM generator with duty=3 (period 256), en=1, wait for three periods → at each rise after the first, valid pulses once with period=256 and high_time=3. No valid is issued at the first rise.
2. Generator with duty=0 (line constant low) → valid never asserts; stuck_low=1 and stuck_high=0 once TIMEOUT=4096 cycles have elapsed since the last rise, and active=0. Then switch to duty=5 → at the first rise stuck_low clears and active=1; the second rise gives valid with period=256, high_time=5.
3. Hold pwm_in=1 through reset release and beyond TIMEOUT → no rise is detected and no valid is issued. If a prior rise had armed the capture, stuck_high=1 after TIMEOUT cycles.
4. Hand-driven fastest waveform (1 cycle high, 1 cycle low) → valid every 2 cycles with period=2, high_time=1. Then 10 high / 30 low → period=40, high_time=10.
5. Mid-period, deassert en for 5 cycles then reassert → the outputs keep the last values, the first post-enable rise gives no valid, and the following rise gives correct values. Repeat with a 1-cycle rst pulse instead → all outputs read 0 until the second rise after reset.
6. Set TIMEOUT=100 with a waveform of period 100 (rise exactly when cnt reaches TIMEOUT) → rise wins: valid with period=100, no stuck flag. With period 101 → stuck flag set and IDLE entered, and the next rise only re-arms.
